dram_port_arbiter: RTL and testbench
====================================

Name: dram_port_arbiter

Overview:
- Shares the single MIG DDR3 user (app_*) interface between two requesters: port 0 is the serial loader and port 1 is the CPU memory port.
- Sits between serial_top's requesters and the MIG instance in the ui_clk domain.
- Holds commands until calibration completes, then arbitrates round-robin.
- Serialises traffic: one outstanding transaction at a time, each returning a one-cycle response.

Parameters:
- ADDR_W, 28, MIG app_addr width (byte address).
- DATA_W, 128, MIG app data width (16-bit DDR3, 4:1 ratio, BL8).
- MASK_W, 16, DATA_W/8; app_wdf_mask bit = 1 means the byte is NOT written.

Ports:
- ui_clk  in  1  MIG user clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- init_calib_complete  in  1  MIG calibration done.
- sN_req_valid  in  1  request from port N (N = 0, 1).
- sN_req_ready  out  1  request accepted this cycle.
- sN_req_we  in  1  1 = write, 0 = read.
- sN_req_addr  in  ADDR_W  byte address; must be DATA_W/8-aligned.
- sN_req_wdata  in  DATA_W  write data.
- sN_req_wmask  in  MASK_W  write byte mask, MIG polarity.
- sN_resp_valid  out  1  one-cycle completion pulse (both reads and writes).
- sN_resp_rdata  out  DATA_W  read data; valid with resp_valid.
- app_addr  out  ADDR_W  MIG address.
- app_cmd  out  3  001 = read, 000 = write.
- app_en  out  1  MIG command valid.
- app_rdy  in  1  MIG command accept.
- app_wdf_data  out  DATA_W  MIG write data.
- app_wdf_mask  out  MASK_W  MIG write mask.
- app_wdf_wren  out  1  MIG write-data valid.
- app_wdf_end  out  1  equals app_wdf_wren (single beat).
- app_wdf_rdy  in  1  MIG write-data accept.
- app_rd_data  in  DATA_W  MIG read data.
- app_rd_data_valid  in  1  MIG read data valid.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0, state = CALIB, last_grant = 1 (port 0 wins first).
- CALIB:
  - sN_req_ready = 0.
  - Go to IDLE on the first cycle init_calib_complete = 1.
  - If calibration drops later, finish the current transaction, then return to CALIB.
- IDLE, grant rule:
  - Only one valid: grant it.
  - Both valid: grant the port != last_grant.
- IDLE, on grant:
  - Assert sN_req_ready for exactly one cycle (combinational, same cycle as valid).
  - Latch we/addr/wdata/wmask and the granted id; set last_grant = id.
  - Go to WR if we = 1, else RD_CMD.
  - Never more than one req_ready per cycle.
- WR:
  - Flags cmd_done and dat_done are cleared on entry.
  - app_en = !cmd_done with app_cmd = 000; app_wdf_wren = app_wdf_end = !dat_done.
  - Set cmd_done on app_en & app_rdy; set dat_done on app_wdf_wren & app_wdf_rdy.
  - Command and data are accepted independently, in either order or the same cycle.
  - When both are done (including a same-cycle final acceptance), go to RESP.
- RD_CMD: app_en = 1, app_cmd = 001. On app_rdy, go to RD_WAIT.
- RD_WAIT:
  - On app_rd_data_valid, latch app_rd_data into the granted port's resp_rdata, then go to RESP.
  - No timeout.
- RESP:
  - sN_resp_valid = 1 for one cycle on the granted port only, then IDLE.
  - A new grant is possible on the following cycle (IDLE).
- Cycle counts with MIG always ready:
  - Write: IDLE, WR, RESP = 3 cycles.
  - Read: IDLE, RD_CMD, RD_WAIT (plus MIG latency), RESP.
- app_addr/app_wdf_data/app_wdf_mask come from registers and stay stable while app_en or app_wdf_wren is asserted.
- Outside the above states: app_en = app_wdf_wren = 0.
- Spurious app_rd_data_valid outside RD_WAIT is ignored.
- resp_rdata holds its last value until the next read completes on that port.
- Reset mid-transaction: immediate return to CALIB with all outputs 0. The requester must re-issue.

Test Plan:
- Calibration hold: rst, init_calib_complete = 0 for 50 cycles with s0 valid → s0_req_ready stays 0, app_en 0. After calib = 1, the grant occurs on the next cycle.
- Single write: s1 write, addr 0x0000040, wdata 0x…DEADBEEF, wmask 0xFFF0, app_rdy = app_wdf_rdy = 1 → app_en and app_wdf_wren each high one cycle with these values, app_cmd = 000; s1_resp_valid one pulse 2 cycles after ready.
- Write with skewed readies: app_rdy delayed 3 cycles, app_wdf_rdy delayed 5 → app_en drops after its accept, wren stays high until cycle 5; resp occurs only after both.
- Read: s0 read, addr 0x100; MIG returns 0x0123…CDEF 7 cycles after command accept → s0_resp_rdata = that value, s0_resp_valid one pulse; s1_resp_valid stays 0.
- Contention: s0 and s1 continuously valid for 6 transactions → grant order 0,1,0,1,0,1. Never two ready in one cycle, never two outstanding app commands.
- Reset mid-read: assert rst in RD_WAIT → all outputs 0 and state CALIB. A later stale app_rd_data_valid produces no resp_valid.

Source files
------------

// File: rtl/dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_port_arbiter
// Purpose  : Shares one MIG DDR3 user interface between the serial loader
//            (port 0) and the CPU memory port (port 1). Commands are held
//            until calibration completes. Arbitration is round-robin, and
//            only one transaction is in flight at a time. Each transaction
//            ends with a single-cycle response pulse on its own port.
// Revision : 1.0 - initial release
// ============================================================================
module dram_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int MASK_W = 16
) (
  input  logic              ui_clk,
  input  logic              rst,
  input  logic              init_calib_complete,
  // port 0 : serial loader
  input  logic              s0_req_valid,
  output logic              s0_req_ready,
  input  logic              s0_req_we,
  input  logic [ADDR_W-1:0] s0_req_addr,
  input  logic [DATA_W-1:0] s0_req_wdata,
  input  logic [MASK_W-1:0] s0_req_wmask,
  output logic              s0_resp_valid,
  output logic [DATA_W-1:0] s0_resp_rdata,
  // port 1 : CPU memory port
  input  logic              s1_req_valid,
  output logic              s1_req_ready,
  input  logic              s1_req_we,
  input  logic [ADDR_W-1:0] s1_req_addr,
  input  logic [DATA_W-1:0] s1_req_wdata,
  input  logic [MASK_W-1:0] s1_req_wmask,
  output logic              s1_resp_valid,
  output logic [DATA_W-1:0] s1_resp_rdata,
  // MIG user interface
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic [MASK_W-1:0] app_wdf_mask,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  output logic              busy
);

  localparam logic [2:0] S_CALIB   = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_WR      = 3'd2;
  localparam logic [2:0] S_RD_CMD  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam logic [2:0] C_CMD_WRITE = 3'b000;
  localparam logic [2:0] C_CMD_READ  = 3'b001;

  logic [2:0]        state_q, state_d;
  logic              cmd_done_q, cmd_done_d;
  logic              dat_done_q, dat_done_d;
  logic              last_grant_q;
  logic              gnt_id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic w_grant;
  logic w_gnt_id;
  logic w_sel_we;
  logic w_wr_cmd_fire;
  logic w_wr_dat_fire;

  // A grant needs IDLE and calibration still good. When both ports request,
  // the port that did not win last time is chosen. Otherwise the only
  // requester is chosen.
  assign w_grant  = (state_q == S_IDLE) & init_calib_complete &
                    (s0_req_valid | s1_req_valid);
  assign w_gnt_id = (s0_req_valid & s1_req_valid) ? ~last_grant_q : s1_req_valid;
  assign w_sel_we = w_gnt_id ? s1_req_we : s0_req_we;

  // Write command and write data handshake independently of each other.
  assign w_wr_cmd_fire = (state_q == S_WR) & ~cmd_done_q & app_rdy;
  assign w_wr_dat_fire = (state_q == S_WR) & ~dat_done_q & app_wdf_rdy;

  // State register with the write handshake flags.
  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_CALIB;
      cmd_done_q <= 1'b0;
      dat_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_done_q <= cmd_done_d;
      dat_done_q <= dat_done_d;
    end
  end

  // Next-state logic. After a transaction, a calibration drop sends the FSM back to CALIB.
  always_comb begin
    state_d    = state_q;
    cmd_done_d = cmd_done_q;
    dat_done_d = dat_done_q;
    case (state_q)
      S_CALIB: begin
        if (init_calib_complete) state_d = S_IDLE;
      end
      S_IDLE: begin
        cmd_done_d = 1'b0;
        dat_done_d = 1'b0;
        if (!init_calib_complete) state_d = S_CALIB;
        else if (w_grant)         state_d = w_sel_we ? S_WR : S_RD_CMD;
      end
      S_WR: begin
        cmd_done_d = cmd_done_q | w_wr_cmd_fire;
        dat_done_d = dat_done_q | w_wr_dat_fire;
        if (cmd_done_d && dat_done_d) state_d = S_RESP;
      end
      S_RD_CMD: begin
        if (app_rdy) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (app_rd_data_valid) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = init_calib_complete ? S_IDLE : S_CALIB;
      end
      default: state_d = S_CALIB;
    endcase
  end

  // Transaction capture at grant time and per-port read-data holding registers.
  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      gnt_id_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      if (w_grant) begin
        gnt_id_q     <= w_gnt_id;
        last_grant_q <= w_gnt_id;
        addr_q       <= w_gnt_id ? s1_req_addr  : s0_req_addr;
        wdata_q      <= w_gnt_id ? s1_req_wdata : s0_req_wdata;
        wmask_q      <= w_gnt_id ? s1_req_wmask : s0_req_wmask;
      end
      if ((state_q == S_RD_WAIT) && app_rd_data_valid) begin
        if (gnt_id_q) rdata1_q <= app_rd_data;
        else          rdata0_q <= app_rd_data;
      end
    end
  end

  // Output decode from the current state. The handshake flags mask already-accepted halves.
  always_comb begin
    s0_req_ready  = w_grant & ~w_gnt_id;
    s1_req_ready  = w_grant &  w_gnt_id;
    app_en        = ((state_q == S_WR) & ~cmd_done_q) | (state_q == S_RD_CMD);
    app_cmd       = (state_q == S_RD_CMD) ? C_CMD_READ : C_CMD_WRITE;
    app_wdf_wren  = (state_q == S_WR) & ~dat_done_q;
    app_wdf_end   = (state_q == S_WR) & ~dat_done_q;
    s0_resp_valid = (state_q == S_RESP) & ~gnt_id_q;
    s1_resp_valid = (state_q == S_RESP) &  gnt_id_q;
    busy          = (state_q != S_IDLE);
  end

  assign app_addr      = addr_q;
  assign app_wdf_data  = wdata_q;
  assign app_wdf_mask  = wmask_q;
  assign s0_resp_rdata = rdata0_q;
  assign s1_resp_rdata = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_port_arbiter
// Purpose  : Directed self-checking bench for dram_port_arbiter
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_port_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int MASK_W = 16;

  localparam logic [DATA_W-1:0] C_WDATA = 128'h0011_2233_4455_6677_8899_AABB_DEAD_BEEF;
  localparam logic [DATA_W-1:0] C_RDATA = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [DATA_W-1:0] C_STALE = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;

  logic              ui_clk;
  logic              rst;
  logic              init_calib_complete;
  logic              s0_req_valid, s0_req_ready, s0_req_we, s0_resp_valid;
  logic [ADDR_W-1:0] s0_req_addr;
  logic [DATA_W-1:0] s0_req_wdata, s0_resp_rdata;
  logic [MASK_W-1:0] s0_req_wmask;
  logic              s1_req_valid, s1_req_ready, s1_req_we, s1_resp_valid;
  logic [ADDR_W-1:0] s1_req_addr;
  logic [DATA_W-1:0] s1_req_wdata, s1_resp_rdata;
  logic [MASK_W-1:0] s1_req_wmask;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [DATA_W-1:0] app_wdf_data, app_rd_data;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_rd_data_valid;
  logic              busy;

  int n_checks;
  int n_fail;

  dram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
    .ui_clk(ui_clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .s0_req_valid(s0_req_valid), .s0_req_ready(s0_req_ready), .s0_req_we(s0_req_we),
    .s0_req_addr(s0_req_addr), .s0_req_wdata(s0_req_wdata), .s0_req_wmask(s0_req_wmask),
    .s0_resp_valid(s0_resp_valid), .s0_resp_rdata(s0_resp_rdata),
    .s1_req_valid(s1_req_valid), .s1_req_ready(s1_req_ready), .s1_req_we(s1_req_we),
    .s1_req_addr(s1_req_addr), .s1_req_wdata(s1_req_wdata), .s1_req_wmask(s1_req_wmask),
    .s1_resp_valid(s1_resp_valid), .s1_resp_rdata(s1_resp_rdata),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid), .busy(busy)
  );

  initial ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; init_calib_complete = 1'b0;
    s0_req_valid = 1'b0; s0_req_we = 1'b0; s0_req_addr = '0; s0_req_wdata = '0; s0_req_wmask = '0;
    s1_req_valid = 1'b0; s1_req_we = 1'b0; s1_req_addr = '0; s1_req_wdata = '0; s1_req_wmask = '0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data = '0; app_rd_data_valid = 1'b0;
    repeat (3) tick();
    n_checks++; if (s0_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s0_ready: got %b want 0", s0_req_ready); end
    n_checks++; if (s1_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s1_ready: got %b want 0", s1_req_ready); end
    n_checks++; if (app_en !== 1'b0) begin n_fail++; $display("FAIL reset_app_en: got %b want 0", app_en); end
    n_checks++; if (app_wdf_wren !== 1'b0 || app_wdf_end !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b/%b want 0/0", app_wdf_wren, app_wdf_end); end
    n_checks++; if ({s0_resp_valid, s1_resp_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 00", {s0_resp_valid, s1_resp_valid}); end
    n_checks++; if (app_addr !== '0 || app_cmd !== 3'b000) begin n_fail++; $display("FAIL reset_app_addr_cmd: got %h/%b want 0/000", app_addr, app_cmd); end
    n_checks++; if (s0_resp_rdata !== '0 || s1_resp_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0", s0_resp_rdata, s1_resp_rdata); end
  endtask

  task automatic test_calib_hold();
    rst = 1'b0;
    s0_req_valid = 1'b1; s0_req_we = 1'b1; s0_req_addr = 28'h0000010;
    s0_req_wdata = 128'h55; s0_req_wmask = 16'h0000;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_checks++; if (s0_req_ready !== 1'b0 || app_en !== 1'b0) begin n_fail++; $display("FAIL calib_hold cycle %0d: ready/app_en got %b/%b want 0/0", i, s0_req_ready, app_en); end
    end
    init_calib_complete = 1'b1;
    #1;
    n_checks++; if (s0_req_ready !== 1'b0) begin n_fail++; $display("FAIL calib_same_cycle_ready: got %b want 0", s0_req_ready); end
    tick();
    n_checks++; if (s0_req_ready !== 1'b1) begin n_fail++; $display("FAIL calib_next_cycle_grant: got %b want 1", s0_req_ready); end
    tick();
    s0_req_valid = 1'b0;
    #1;
    n_checks++; if (app_en !== 1'b1 || app_wdf_wren !== 1'b1 || app_addr !== 28'h0000010 || app_wdf_data !== 128'h55) begin
      n_fail++; $display("FAIL calib_first_write: en/wren/addr/data got %b/%b/%h/%h want 1/1/0000010/55", app_en, app_wdf_wren, app_addr, app_wdf_data); end
    tick();
    n_checks++; if (s0_resp_valid !== 1'b1) begin n_fail++; $display("FAIL calib_first_resp: got %b want 1", s0_resp_valid); end
    tick();
  endtask

  task automatic test_single_write();
    s1_req_valid = 1'b1; s1_req_we = 1'b1; s1_req_addr = 28'h0000040;
    s1_req_wdata = C_WDATA; s1_req_wmask = 16'hFFF0;
    #1;
    n_checks++; if ({s1_req_ready, s0_req_ready} !== 2'b10) begin n_fail++; $display("FAIL wr_grant: s1/s0 ready got %b want 10", {s1_req_ready, s0_req_ready}); end
    tick();
    s1_req_valid = 1'b0;
    #1;
    n_checks++; if (app_en !== 1'b1 || app_cmd !== 3'b000) begin n_fail++; $display("FAIL wr_cmd: en/cmd got %b/%b want 1/000", app_en, app_cmd); end
    n_checks++; if (app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1) begin n_fail++; $display("FAIL wr_wren: wren/end got %b/%b want 1/1", app_wdf_wren, app_wdf_end); end
    n_checks++; if (app_addr !== 28'h0000040) begin n_fail++; $display("FAIL wr_addr: got %h want 0000040", app_addr); end
    n_checks++; if (app_wdf_data !== C_WDATA || app_wdf_mask !== 16'hFFF0) begin n_fail++; $display("FAIL wr_data_mask: got %h/%h want %h/fff0", app_wdf_data, app_wdf_mask, C_WDATA); end
    n_checks++; if (s1_resp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_resp_early: got %b want 0", s1_resp_valid); end
    tick();
    n_checks++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b0) begin n_fail++; $display("FAIL wr_single_beat: en/wren got %b/%b want 0/0", app_en, app_wdf_wren); end
    n_checks++; if ({s1_resp_valid, s0_resp_valid} !== 2'b10) begin n_fail++; $display("FAIL wr_resp: s1/s0 got %b want 10", {s1_resp_valid, s0_resp_valid}); end
    tick();
    n_checks++; if (s1_resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL wr_resp_one_cycle: resp/busy got %b/%b want 0/0", s1_resp_valid, busy); end
  endtask

  task automatic test_skewed_write();
    s0_req_valid = 1'b1; s0_req_we = 1'b1; s0_req_addr = 28'h0000080;
    s0_req_wdata = 128'hCAFE; s0_req_wmask = 16'h00FF;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    tick();
    s0_req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      app_rdy     = (k == 3);
      app_wdf_rdy = (k == 5);
      #1;
      n_checks++; if (app_en !== (k <= 3)) begin n_fail++; $display("FAIL skew_app_en wr cycle %0d: got %b want %b", k, app_en, (k <= 3)); end
      n_checks++; if (app_wdf_wren !== 1'b1) begin n_fail++; $display("FAIL skew_wren wr cycle %0d: got %b want 1", k, app_wdf_wren); end
      n_checks++; if (s0_resp_valid !== 1'b0) begin n_fail++; $display("FAIL skew_resp_early wr cycle %0d: got %b want 0", k, s0_resp_valid); end
      tick();
    end
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    #1;
    n_checks++; if (s0_resp_valid !== 1'b1 || app_en !== 1'b0 || app_wdf_wren !== 1'b0) begin
      n_fail++; $display("FAIL skew_resp: resp/en/wren got %b/%b/%b want 1/0/0", s0_resp_valid, app_en, app_wdf_wren); end
    tick();
  endtask

  task automatic test_read();
    s0_req_valid = 1'b1; s0_req_we = 1'b0; s0_req_addr = 28'h0000100;
    #1;
    n_checks++; if (s0_req_ready !== 1'b1) begin n_fail++; $display("FAIL rd_grant: got %b want 1", s0_req_ready); end
    tick();
    s0_req_valid = 1'b0;
    #1;
    n_checks++; if (app_en !== 1'b1 || app_cmd !== 3'b001 || app_addr !== 28'h0000100 || app_wdf_wren !== 1'b0) begin
      n_fail++; $display("FAIL rd_cmd: en/cmd/addr/wren got %b/%b/%h/%b want 1/001/0000100/0", app_en, app_cmd, app_addr, app_wdf_wren); end
    tick();
    for (int w = 1; w <= 7; w++) begin
      app_rd_data       = (w == 7) ? C_RDATA : '0;
      app_rd_data_valid = (w == 7);
      #1;
      n_checks++; if (s0_resp_valid !== 1'b0 || app_en !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL rd_wait cycle %0d: resp/en/busy got %b/%b/%b want 0/0/1", w, s0_resp_valid, app_en, busy); end
      tick();
    end
    app_rd_data_valid = 1'b0; app_rd_data = '0;
    #1;
    n_checks++; if ({s1_resp_valid, s0_resp_valid} !== 2'b01) begin n_fail++; $display("FAIL rd_resp: s1/s0 got %b want 01", {s1_resp_valid, s0_resp_valid}); end
    n_checks++; if (s0_resp_rdata !== C_RDATA) begin n_fail++; $display("FAIL rd_rdata: got %h want %h", s0_resp_rdata, C_RDATA); end
    tick();
    // stray read data while idle must not disturb the held value
    app_rd_data = C_STALE; app_rd_data_valid = 1'b1;
    #1;
    n_checks++; if (s0_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_resp_one_cycle: got %b want 0", s0_resp_valid); end
    tick();
    app_rd_data_valid = 1'b0;
    #1;
    n_checks++; if (s0_resp_rdata !== C_RDATA || s1_resp_rdata !== '0) begin n_fail++; $display("FAIL rd_hold: s0/s1 rdata got %h/%h want %h/0", s0_resp_rdata, s1_resp_rdata, C_RDATA); end
    n_checks++; if (s0_resp_valid !== 1'b0 || s1_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_spurious_resp: got %b/%b want 0/0", s0_resp_valid, s1_resp_valid); end
  endtask

  task automatic test_reset_mid_read();
    s1_req_valid = 1'b1; s1_req_we = 1'b0; s1_req_addr = 28'h0000500;
    tick();
    s1_req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || app_addr !== '0) begin n_fail++; $display("FAIL rst_mid_app: en/wren/addr got %b/%b/%h want 0/0/0", app_en, app_wdf_wren, app_addr); end
    n_checks++; if ({s0_req_ready, s1_req_ready, s0_resp_valid, s1_resp_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid_handshake: got %b want 0000", {s0_req_ready, s1_req_ready, s0_resp_valid, s1_resp_valid}); end
    n_checks++; if (s0_resp_rdata !== '0) begin n_fail++; $display("FAIL rst_mid_rdata: got %h want 0", s0_resp_rdata); end
    tick();
    rst = 1'b0; init_calib_complete = 1'b0;
    s0_req_valid = 1'b1; s0_req_we = 1'b0; s0_req_addr = 28'h0000020;
    app_rd_data = C_STALE; app_rd_data_valid = 1'b1;
    tick();
    n_checks++; if (s0_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_calib: ready got %b want 0", s0_req_ready); end
    n_checks++; if (s1_resp_valid !== 1'b0 || s0_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale_resp: got %b/%b want 0/0", s0_resp_valid, s1_resp_valid); end
    s0_req_valid = 1'b0; init_calib_complete = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (s1_resp_valid !== 1'b0 || s1_resp_rdata !== '0) begin
        n_fail++; $display("FAIL rst_mid_stale cycle %0d: resp/rdata got %b/%h want 0/0", i, s1_resp_valid, s1_resp_rdata); end
    end
    app_rd_data_valid = 1'b0; app_rd_data = '0;
  endtask

  task automatic test_contention();
    int grants[8];
    int ng;
    int nresp;
    int outstanding;
    logic [ADDR_W-1:0] exp_addr;
    ng = 0; nresp = 0; outstanding = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0; init_calib_complete = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    s0_req_valid = 1'b1; s0_req_we = 1'b1; s0_req_addr = 28'h0000200; s0_req_wdata = 128'hA0; s0_req_wmask = '0;
    s1_req_valid = 1'b1; s1_req_we = 1'b1; s1_req_addr = 28'h0000300; s1_req_wdata = 128'hB1; s1_req_wmask = '0;
    #1;
    for (int cyc = 0; cyc < 60 && nresp < 6; cyc++) begin
      n_checks++; if (s0_req_ready && s1_req_ready) begin n_fail++; $display("FAIL cont_two_ready cycle %0d: got 11 want at most one", cyc); end
      if ((s0_req_ready || s1_req_ready) && ng < 8) begin
        grants[ng] = s1_req_ready ? 1 : 0;
        ng++;
      end
      if (app_en && app_rdy) begin
        outstanding++;
        exp_addr = (grants[ng-1] == 1) ? 28'h0000300 : 28'h0000200;
        n_checks++; if (outstanding > 1) begin n_fail++; $display("FAIL cont_outstanding cycle %0d: got %0d want 1", cyc, outstanding); end
        n_checks++; if (app_addr !== exp_addr) begin n_fail++; $display("FAIL cont_addr cycle %0d: got %h want %h", cyc, app_addr, exp_addr); end
      end
      if (s0_resp_valid || s1_resp_valid) begin
        n_checks++; if ({s1_resp_valid, s0_resp_valid} !== ((grants[ng-1] == 1) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL cont_resp_port cycle %0d: s1/s0 got %b for grant %0d", cyc, {s1_resp_valid, s0_resp_valid}, grants[ng-1]); end
        outstanding--;
        nresp++;
      end
      tick();
      if (ng >= 6) begin
        s0_req_valid = 1'b0; s1_req_valid = 1'b0;
        #1;
      end
    end
    n_checks++; if (ng !== 6 || nresp !== 6) begin n_fail++; $display("FAIL cont_count: grants/resps got %0d/%0d want 6/6", ng, nresp); end
    for (int i = 0; i < 6 && i < ng; i++) begin
      n_checks++; if (grants[i] !== (i % 2)) begin n_fail++; $display("FAIL cont_order[%0d]: got %0d want %0d", i, grants[i], i % 2); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_calib_hold();
    test_single_write();
    test_skewed_write();
    test_read();
    test_reset_mid_read();
    test_contention();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
